// File: rtl/sum_latch_uart_core.sv
// Operand latch bank with registered sum and a byte-serial UART transmitter.
// Strobes and the transmit request come from pins and are synchronised here.
module sum_latch_uart_core #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned NUM_OPS      = 2,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  localparam int unsigned SUM_W       = DATA_W + $clog2(NUM_OPS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  data_input,
  input  logic [NUM_OPS-1:0] save_n,
  input  logic               uart_tx_en,
  output logic [SUM_W-1:0]   sum_out,
  output logic               uartbusy,
  output logic               uart_txd
);

  localparam int unsigned NUM_BYTES = (SUM_W + 7) / 8;
  localparam int unsigned SNAP_W    = NUM_BYTES * 8;
  localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  logic [NUM_OPS-1:0] save_s1_q, save_s1_d;
  logic [NUM_OPS-1:0] save_s2_q, save_s2_d;
  logic [NUM_OPS-1:0] save_s3_q, save_s3_d;
  logic               tx_s1_q, tx_s1_d;
  logic               tx_s2_q, tx_s2_d;
  logic               tx_s3_q, tx_s3_d;
  logic [NUM_OPS-1:0] save_fall_c;
  logic               tx_req_c;

  logic [DATA_W-1:0]  op_q [NUM_OPS];
  logic [DATA_W-1:0]  op_d [NUM_OPS];
  logic [SUM_W-1:0]   sum_q, sum_d;

  tx_state_e          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               baud_end_c;
  logic [7:0]         cur_byte_c;

  // Two-flop synchronisers plus a third stage for edge detection
  always_comb begin
    save_s1_d   = save_n;
    save_s2_d   = save_s1_q;
    save_s3_d   = save_s2_q;
    tx_s1_d     = uart_tx_en;
    tx_s2_d     = tx_s1_q;
    tx_s3_d     = tx_s2_q;
    save_fall_c = save_s3_q & ~save_s2_q;
    tx_req_c    = tx_s2_q & ~tx_s3_q;
  end

  // Operand loads and full-width sum
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < int'(NUM_OPS); i++) begin
      op_d[i] = save_fall_c[i] ? data_input : op_q[i];
      sum_d   = sum_d + SUM_W'(op_q[i]);
    end
  end

  always_comb begin
    baud_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    cur_byte_c = 8'(snap_q >> {byte_q, 3'b000});
  end

  // Transmit FSM: next state, counters and registered line/busy values
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (tx_req_c) begin
          state_d = S_START;
          snap_d  = SNAP_W'(sum_q);
          byte_d  = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          txd_d   = cur_byte_c[0];
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              txd_d   = ^cur_byte_c;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = cur_byte_c[bit_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (baud_end_c) begin
          baud_d  = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (byte_q == BYTE_W'(NUM_BYTES - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
            txd_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      save_s1_q <= '1;
      save_s2_q <= '1;
      save_s3_q <= '1;
      tx_s1_q   <= 1'b0;
      tx_s2_q   <= 1'b0;
      tx_s3_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_OPS); i++) op_q[i] <= '0;
      sum_q     <= '0;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      snap_q    <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      save_s1_q <= save_s1_d;
      save_s2_q <= save_s2_d;
      save_s3_q <= save_s3_d;
      tx_s1_q   <= tx_s1_d;
      tx_s2_q   <= tx_s2_d;
      tx_s3_q   <= tx_s3_d;
      for (int i = 0; i < int'(NUM_OPS); i++) op_q[i] <= op_d[i];
      sum_q     <= sum_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      snap_q    <= snap_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  assign sum_out  = sum_q;
  assign uartbusy = busy_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_sum_latch_uart_core.sv
// Bench for sum_latch_uart_core: cycle model for the default build, directed
// frame decoding for a 12-bit, 4-operand, even-parity build.
module tb_sum_latch_uart_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, tx0_en, busy0, txd0;
  logic [3:0]  data0;
  logic [1:0]  save0_n;
  logic [4:0]  sum0;

  logic        rst1_n, tx1_en, busy1, txd1;
  logic [11:0] data1;
  logic [3:0]  save1_n;
  logic [13:0] sum1;

  sum_latch_uart_core dut0 (
    .clk(clk), .reset_n(rst0_n), .data_input(data0), .save_n(save0_n),
    .uart_tx_en(tx0_en), .sum_out(sum0), .uartbusy(busy0), .uart_txd(txd0)
  );

  sum_latch_uart_core #(.DATA_W(12), .NUM_OPS(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .data_input(data1), .save_n(save1_n),
    .uart_tx_en(tx1_en), .sum_out(sum1), .uartbusy(busy1), .uart_txd(txd1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of dut0: inputs take effect two edges after sampling; a frame is a
  // list of per-cycle line levels consumed one per clock.
  logic [1:0] m_sh [4];
  logic       m_th [4];
  int         m_ops [2];
  int         m_sum;
  logic       m_wave [$];

  always @(negedge clk) begin : model_cmp
    int   snap;
    bit   idle;
    logic exp_txd;
    if (!rst0_n) begin
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 2'b11;
        m_th[i] = 1'b0;
      end
      m_ops[0] = 0;
      m_ops[1] = 0;
      m_sum    = 0;
      m_wave.delete();
    end else begin
      for (int i = 3; i > 0; i--) begin
        m_sh[i] = m_sh[i-1];
        m_th[i] = m_th[i-1];
      end
      m_sh[0] = save0_n;
      m_th[0] = tx0_en;
      idle    = (m_wave.size() == 0);
      snap    = m_sum;
      m_sum   = m_ops[0] + m_ops[1];
      for (int i = 0; i < 2; i++)
        if (!m_sh[2][i] && m_sh[3][i]) m_ops[i] = int'(data0);
      if (!idle) void'(m_wave.pop_front());
      if (idle && m_th[2] && !m_th[3]) begin
        for (int j = 0; j < 10; j++) begin
          logic b;
          if (j == 0) b = 1'b0;
          else if (j == 9) b = 1'b1;
          else b = snap[j-1];
          repeat (16) m_wave.push_back(b);
        end
      end
      exp_txd = (m_wave.size() > 0) ? m_wave[0] : 1'b1;
      chk("model_sum_out", 32'(sum0), 32'(m_sum));
      chk("model_uartbusy", 32'(busy0), 32'(m_wave.size() > 0));
      chk("model_uart_txd", 32'(txd0), 32'(exp_txd));
    end
  end

  logic rx_q [$];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Records the line level every cycle that busy is high
  task automatic rx_capture(input int which, output int len);
    int t;
    rx_q.delete();
    t = 0;
    while (t < 3000 && !((which == 0) ? busy0 : busy1)) begin
      @(negedge clk);
      t++;
    end
    chk("rx_busy_rise", 32'((which == 0) ? busy0 : busy1), 32'd1);
    t = 0;
    while (((which == 0) ? busy0 : busy1) && t < 2000) begin
      rx_q.push_back((which == 0) ? txd0 : txd1);
      @(negedge clk);
      t++;
    end
    len = rx_q.size();
  endtask

  function automatic logic rx_slot(input int cpb, input int bits, input int b, input int j);
    int idx = (b * bits + j) * cpb + cpb / 2;
    if (idx < rx_q.size()) return rx_q[idx];
    return 1'bx;
  endfunction

  function automatic logic [7:0] rx_byte(input int cpb, input int bits, input int b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = rx_slot(cpb, bits, b, k + 1);
    return r;
  endfunction

  task automatic pulse0();
    tx0_en = 1'b1;
    step(2);
    tx0_en = 1'b0;
  endtask

  task automatic pulse1();
    tx1_en = 1'b1;
    step(2);
    tx1_en = 1'b0;
  endtask

  task automatic wait_idle0();
    int t = 0;
    while (busy0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    #1;
    chk("wait_idle0", 32'(busy0), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, rises, bc, low, t;
    logic [9:0] v;
    logic prev;
    rst0_n = 1'b1; rst1_n = 1'b1;
    data0 = '0; save0_n = 2'b11; tx0_en = 1'b0;
    data1 = '0; save1_n = 4'hF;  tx1_en = 1'b0;
    #2;
    rst0_n = 1'b0; rst1_n = 1'b0;
    #1;
    chk("reset_sum", 32'(sum0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_txd", 32'(txd0), 32'd1);
    step(3);
    rst0_n = 1'b1;
    step(2);

    // A=9, B=7 -> 0x10
    data0 = 4'd9; save0_n = 2'b10; step(3); save0_n = 2'b11; step(2);
    data0 = 4'd7; save0_n = 2'b01; step(3); save0_n = 2'b11; step(5);
    chk("sum_9_plus_7", 32'(sum0), 32'h10);
    pulse0();
    rx_capture(0, len);
    chk("busy_len_default", 32'(len), 32'd160);
    for (int j = 0; j < 10; j++) v[j] = rx_slot(16, 10, 0, j);
    chk("frame_bits_0x10", 32'(v), 32'h220);
    step(3);

    // Simultaneous save of both operands, maximum values
    data0 = 4'd15; save0_n = 2'b00; step(3); save0_n = 2'b11; step(5);
    chk("sum_15_plus_15", 32'(sum0), 32'h1E);
    pulse0();
    rx_capture(0, len);
    chk("byte_0x1e", 32'(rx_byte(16, 10, 0)), 32'h1E);
    chk("stop_bit_0x1e", 32'(rx_slot(16, 10, 0, 9)), 32'd1);
    step(3);

    // Held request produces one frame only
    tx0_en = 1'b1;
    rises = 0; prev = busy0;
    repeat (1000) begin
      @(negedge clk);
      if (busy0 && !prev) rises++;
      prev = busy0;
    end
    #1;
    tx0_en = 1'b0;
    chk("held_req_one_frame", 32'(rises), 32'd1);
    step(3);

    // Request sampled on the edge busy falls starts the next frame 2 edges later
    pulse0();
    t = 0;
    while (!busy0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_first_busy", 32'(busy0), 32'd1);
    repeat (159) @(negedge clk);
    #1;
    tx0_en = 1'b1;
    low = 0; t = 0;
    @(negedge clk);
    while (!busy0 && t < 10) begin
      low++;
      @(negedge clk);
      t++;
    end
    chk("b2b_gap_cycles", 32'(low), 32'd2);
    #1;
    tx0_en = 1'b0;
    wait_idle0();
    step(2);

    // Operand change mid-frame leaves the snapshot alone
    pulse0();
    fork
      rx_capture(0, len);
      begin
        step(55);
        data0 = 4'd1; save0_n = 2'b10; step(3); save0_n = 2'b11;
      end
    join
    chk("snapshot_kept", 32'(rx_byte(16, 10, 0)), 32'h1E);
    step(2);
    chk("sum_after_midframe_save", 32'(sum0), 32'h10);

    // Asynchronous reset in the middle of the data bits
    pulse0();
    step(50);
    chk("pre_reset_busy", 32'(busy0), 32'd1);
    rst0_n = 1'b0;
    #1;
    chk("midframe_reset_txd", 32'(txd0), 32'd1);
    chk("midframe_reset_busy", 32'(busy0), 32'd0);
    chk("midframe_reset_sum", 32'(sum0), 32'd0);
    step(2);
    rst0_n = 1'b1;
    step(4);
    chk("post_reset_sum", 32'(sum0), 32'd0);

    // 12-bit, 4 operands, even parity, 4 clocks per bit
    rst1_n = 1'b1;
    step(2);
    data1 = 12'd4; save1_n = 4'h0; step(3); save1_n = 4'hF; step(6);
    chk("p_sum_0x10", 32'(sum1), 32'h10);
    pulse1();
    rx_capture(1, len);
    chk("p_busy_len", 32'(len), 32'd88);
    chk("p_byte0", 32'(rx_byte(4, 11, 0)), 32'h10);
    chk("p_parity0", 32'(rx_slot(4, 11, 0, 9)), 32'd1);
    chk("p_stop0", 32'(rx_slot(4, 11, 0, 10)), 32'd1);
    chk("p_start1", 32'(rx_slot(4, 11, 1, 0)), 32'd0);
    chk("p_byte1", 32'(rx_byte(4, 11, 1)), 32'h00);
    chk("p_parity1", 32'(rx_slot(4, 11, 1, 9)), 32'd0);
    #1;

    // Second request during the frame is dropped
    rises = 0; bc = 0; prev = busy1;
    for (int i = 0; i < 200; i++) begin
      tx1_en = (i < 2) || (i >= 30 && i < 32);
      @(negedge clk);
      if (busy1 && !prev) rises++;
      if (busy1) bc++;
      prev = busy1;
      #1;
    end
    tx1_en = 1'b0;
    chk("p_midframe_req_frames", 32'(rises), 32'd1);
    chk("p_midframe_req_busy", 32'(bc), 32'd88);

    data1 = 12'hFFF; save1_n = 4'h0; step(3); save1_n = 4'hF; step(6);
    chk("p_sum_0x3ffc", 32'(sum1), 32'h3FFC);
    pulse1();
    rx_capture(1, len);
    chk("p2_busy_len", 32'(len), 32'd88);
    chk("p2_byte0", 32'(rx_byte(4, 11, 0)), 32'hFC);
    chk("p2_byte1", 32'(rx_byte(4, 11, 1)), 32'h3F);
    chk("p2_parity0", 32'(rx_slot(4, 11, 0, 9)), 32'd0);
    chk("p2_parity1", 32'(rx_slot(4, 11, 1, 9)), 32'd0);
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
